seq_bit_serializer: RTL and testbench

// - Upstream feeder for the serial sequence-detector stage: accepts parallel words over a

---
 rtl/seq_bit_serializer.sv | 197 +++++++++++++++++++
 tb/tb_seq_bit_serializer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
//   Accepts parallel words over a valid/ready handshake, buffers them in a
//   DEPTH-word FIFO and shifts them out MSB first, one bit per cycle, to feed
//   a serial sequence detector.
//
// Parameters
//   WIDTH  word width in bits (>=2)
//   DEPTH  FIFO depth in words (power of two, >=2)
//   GAP    forced idle cycles between consecutive words (0..15)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   in_data     parallel word, MSB transmitted first
//   in_valid    in_data valid
//   in_ready    FIFO can accept (= !full, from registered count)
//   en          shift enable; 0 stalls the serializer, FIFO writes still accepted
//   dout        serial bit (registered)
//   dout_valid  dout carries a new bit this cycle (registered)
//   busy        FSM not idle or FIFO non-empty
//
// Build option
//   SEQ_SER_PARITY_EN  append one even-parity bit (XOR of the word) after the LSB
module seq_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = 4;

`ifdef SEQ_SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  // FIFO
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Serializer FSM
  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             dout_n, dout_valid_n;
  logic             load, word_done;
`ifdef SEQ_SER_PARITY_EN
  logic             par_bit, par_bit_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
`ifdef SEQ_SER_PARITY_EN
      par_bit    <= par_bit_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    load         = 1'b0;
    word_done    = 1'b0;
`ifdef SEQ_SER_PARITY_EN
    par_bit_n    = par_bit;
`endif

    case (state)
      S_IDLE: begin
        if (en && !empty) load = 1'b1;
        else              state_n = S_IDLE;
      end
      S_SHIFT: begin
        if (en) begin
          dout_n       = shreg[WIDTH-1];
          dout_valid_n = 1'b1;
          shreg_n      = shreg << 1;
          bit_cnt_n    = bit_cnt - 1'b1;
          if (bit_cnt == BW'(1)) begin
`ifdef SEQ_SER_PARITY_EN
            state_n = S_PAR;
`else
            word_done = 1'b1;
`endif
          end
        end
      end
`ifdef SEQ_SER_PARITY_EN
      S_PAR: begin
        if (en) begin
          dout_n       = par_bit;
          dout_valid_n = 1'b1;
          word_done    = 1'b1;
        end
      end
`endif
      S_GAP: begin
        // Leaving on the final gap cycle (and popping if possible) keeps the
        // idle stretch between words at exactly GAP cycles.
        gap_cnt_n = gap_cnt - 1'b1;
        if (gap_cnt <= GW'(1)) begin
          gap_cnt_n = '0;
          if (en && !empty) load = 1'b1;
          else              state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (word_done) begin
      if (GAP > 0) begin
        state_n   = S_GAP;
        gap_cnt_n = GW'(GAP);
      end else if (!empty) begin
        load = 1'b1;
      end else begin
        state_n = S_IDLE;
      end
    end

    // Load overrides the shift update so the next word starts in the same edge.
    if (load) begin
      state_n   = S_SHIFT;
      shreg_n   = mem[rd_ptr];
      bit_cnt_n = BW'(WIDTH);
`ifdef SEQ_SER_PARITY_EN
      par_bit_n = ^mem[rd_ptr];
`endif
    end
  end

  assign pop  = load;
  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: two instances (GAP=0 and GAP=2) share one
// stimulus; a queue-based model predicts every output each cycle, and directed
// scenarios pin the model with hand-computed bit patterns and timings.
module tb_seq_bit_serializer;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SEQ_SER_PARITY_EN
  localparam int BPW = W + 1;
`else
  localparam int BPW = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid, en;
  logic [1:0]   in_ready, dout, dout_valid, busy;

  seq_bit_serializer #(.WIDTH(W), .DEPTH(D), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .en(en), .dout(dout[0]),
    .dout_valid(dout_valid[0]), .busy(busy[0]));

  seq_bit_serializer #(.WIDTH(W), .DEPTH(D), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .en(en), .dout(dout[1]),
    .dout_valid(dout_valid[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words wait in a bounded queue, the word being sent is a
  // queue of bits, and a countdown covers the forced gap.
  int           gaps[2] = '{0, 2};
  logic [W-1:0] m_fifo[2][$];
  bit           m_cur[2][$];
  int           m_gap[2];
  logic         m_dout[2];
  logic         m_dv[2];
  int           edge_n = 0;

  task automatic m_load(input int i);
    logic [W-1:0] w;
    w = m_fifo[i].pop_front();
    for (int b = W - 1; b >= 0; b--) m_cur[i].push_back(w[b]);
`ifdef SEQ_SER_PARITY_EN
    m_cur[i].push_back(^w);
`endif
  endtask

  always @(posedge clk or posedge reset) begin : model
    bit rdy;
    bit nonempty;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_fifo[i].delete();
        m_cur[i].delete();
        m_gap[i]  = 0;
        m_dout[i] = 1'b0;
        m_dv[i]   = 1'b0;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        rdy      = m_fifo[i].size() < D;
        nonempty = m_fifo[i].size() > 0;
        m_dv[i]  = 1'b0;
        if (m_cur[i].size() > 0) begin
          if (en) begin
            m_dout[i] = m_cur[i].pop_front();
            m_dv[i]   = 1'b1;
            if (m_cur[i].size() == 0) begin
              if (gaps[i] > 0) m_gap[i] = gaps[i];
              else if (nonempty) m_load(i);
            end
          end
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
          if (m_gap[i] == 0 && en && nonempty) m_load(i);
        end else if (en && nonempty) begin
          m_load(i);
        end
        if (in_valid && rdy) m_fifo[i].push_back(in_data);
      end
    end
  end

  // Capture of emitted bits and timing facts for the directed checks.
  bit   cap[2][$];
  int   gaplen[2][$];
  int   zrun[2];
  int   runs0;
  int   first_edge0;
  logic prev_dv0 = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dout%0d", i), dout[i], m_dout[i]);
      check($sformatf("dout_valid%0d", i), dout_valid[i], m_dv[i]);
      check($sformatf("in_ready%0d", i), in_ready[i], m_fifo[i].size() < D);
      check($sformatf("busy%0d", i), busy[i],
            m_cur[i].size() > 0 || m_gap[i] > 0 || m_fifo[i].size() > 0);
      if (dout_valid[i] === 1'b1) begin
        if (i == 0 && cap[0].size() == 0) first_edge0 = edge_n;
        if (zrun[i] > 0 && cap[i].size() > 0) gaplen[i].push_back(zrun[i]);
        zrun[i] = 0;
        cap[i].push_back(dout[i]);
      end else begin
        zrun[i]++;
      end
    end
    if (dout_valid[0] === 1'b1 && prev_dv0 !== 1'b1) runs0++;
    prev_dv0 = dout_valid[0];
  end

  function automatic logic [W-1:0] capword(input int i, input int j);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) r[W-1-b] = cap[i][j*BPW+b];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    for (int i = 0; i < 2; i++) begin
      cap[i].delete();
      gaplen[i].delete();
      zrun[i] = 0;
    end
    runs0       = 0;
    first_edge0 = -1;
  endtask

  task automatic push_word(input logic [W-1:0] w, output int k);
    tick();
    in_data  = w;
    in_valid = 1'b1;
    tick();
    k        = edge_n;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick();
    while (busy !== 2'b00 && n < 400) begin
      tick();
      n++;
    end
    check({name, "_idle"}, busy, 2'b00);
    tick();
  endtask

  task automatic wait_bits(input int n, input string name);
    int t;
    t = 0;
    while (cap[0].size() < n && t < 100) begin
      tick();
      t++;
    end
    check({name, "_reach"}, cap[0].size() >= n, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [W-1:0] fillw[5];
    fillw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    reset = 1'b1; in_valid = 1'b0; en = 1'b0; in_data = '0;
    clear();
    repeat (3) tick();
    check("rst_dout", dout, 2'b00);
    check("rst_dv", dout_valid, 2'b00);
    check("rst_ready", in_ready, 2'b11);
    check("rst_busy", busy, 2'b00);
    reset = 1'b0;
    tick();

    // Single word: 1,0,1,1,0,1,0,1 starting two edges after accept
    clear(); en = 1'b1;
    push_word(8'hB5, k);
    wait_idle("b5");
    check("b5_len", cap[0].size(), BPW);
    check("b5_word", capword(0, 0), 8'hB5);
    check("b5_latency", first_edge0, k + 2);
    check("b5_contig", runs0, 1);
`ifdef SEQ_SER_PARITY_EN
    check("b5_parity", cap[0][W], 1);
`endif

    // Back-to-back words; GAP=0 contiguous, GAP=2 exactly two idle cycles
    clear();
    push_word(8'h0A, k);
    push_word(8'hA0, k);
    wait_idle("b2b");
    check("b2b_len", cap[0].size(), 2 * BPW);
    check("b2b_w0", capword(0, 0), 8'h0A);
    check("b2b_w1", capword(0, 1), 8'hA0);
    check("b2b_contig", runs0, 1);
    check("b2b_nogap0", gaplen[0].size(), 0);
    check("gap2_count", gaplen[1].size(), 1);
    check("gap2_len", gaplen[1].size() > 0 ? gaplen[1][0] : -1, 2);
    check("gap2_w1", capword(1, 1), 8'hA0);

    // Fill with en=0: fifth word refused, four words out in order
    clear(); en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("fill_ready%0d", j), in_ready[0], j < 4);
      in_data  = fillw[j];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("fill_full", in_ready[0], 0);
    check("fill_quiet", cap[0].size(), 0);
    en = 1'b1;
    wait_idle("fill");
    check("fill_len", cap[0].size(), 4 * BPW);
    for (int j = 0; j < 4; j++) check($sformatf("fill_w%0d", j), capword(0, j), fillw[j]);
    check("fill_contig", runs0, 1);

    // Stall for three cycles after the third bit of 0xB5
    clear();
    push_word(8'hB5, k);
    wait_bits(3, "stall");
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("stall_dv%0d", j), dout_valid[0], 0);
      check($sformatf("stall_dout%0d", j), dout[0], 1);
    end
    en = 1'b1;
    wait_idle("stall");
    check("stall_len", cap[0].size(), BPW);
    check("stall_word", capword(0, 0), 8'hB5);
    check("stall_runs", runs0, 2);

    // 0x03: parity bit 0 when enabled
    clear();
    push_word(8'h03, k);
    wait_idle("w03");
    check("w03_word", capword(0, 0), 8'h03);
`ifdef SEQ_SER_PARITY_EN
    check("w03_parity", cap[0][W], 0);
`endif

    // Reset mid-stream: immediate clear, nothing old afterwards
    clear();
    push_word(8'h3C, k);
    push_word(8'h5A, k);
    wait_bits(3, "mrst");
    #2;
    reset = 1'b1;
    #1;
    check("mrst_dout", dout, 2'b00);
    check("mrst_dv", dout_valid, 2'b00);
    check("mrst_ready", in_ready, 2'b11);
    check("mrst_busy", busy, 2'b00);
    tick(); tick();
    reset = 1'b0;
    clear();
    repeat (30) tick();
    check("mrst_silent0", cap[0].size(), 0);
    check("mrst_silent1", cap[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
